// File: rtl/iot_relay_driver_if.sv
// Bus between the output PIO and the relay driver: channel requests in, drive/status out.
// switch_count exists only when IOT_RELAY_DRIVER_STATS_EN is defined.
interface iot_relay_driver_if;
  logic [3:0]  cmd_in;
  logic [3:0]  drive;
  logic        busy;
  logic [3:0]  pending;
`ifdef IOT_RELAY_DRIVER_STATS_EN
  logic [15:0] switch_count;

  modport master (output cmd_in, input drive, input busy, input pending, input switch_count);
  modport slave  (input cmd_in, output drive, output busy, output pending, output switch_count);
`else
  modport master (output cmd_in, input drive, input busy, input pending);
  modport slave  (input cmd_in, output drive, output busy, output pending);
`endif
endinterface

// File: rtl/iot_relay_driver.sv
// Four-channel relay driver: serialises channel toggles with a global settle gap and per-channel hold time.
// Optional toggle statistics counter enabled by IOT_RELAY_DRIVER_STATS_EN.
module iot_relay_driver #(
  parameter int unsigned SETTLE_CYCLES = 1000,
  parameter int unsigned HOLD_CYCLES   = 50000
) (
  input  logic             clk,
  input  logic             reset_n,
  iot_relay_driver_if.slave bus
);

  typedef enum logic {IDLE = 1'b0, SETTLE = 1'b1} state_t;

  localparam logic [15:0] SETTLE_LOAD = 16'(SETTLE_CYCLES - 1);
  localparam logic [19:0] HOLD_LOAD   = 20'(HOLD_CYCLES - 1);

  state_t      state_reg, state_next;
  logic [15:0] settle_reg, settle_next;
  logic [3:0]  cmd_q_reg;
  logic [3:0]  drive_reg, drive_next;
  logic [3:0]  pending;
  logic [3:0]  hold_zero;
  logic [3:0]  eligible;
  logic [3:0]  toggle_mask;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cmd_q_reg <= 4'd0;
    end else begin
      cmd_q_reg <= bus.cmd_in;
    end
  end

  assign pending = cmd_q_reg ^ drive_reg;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_hold
      logic [19:0] hold_cnt_reg;

      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          hold_cnt_reg <= 20'd0;
        end else if (toggle_mask[gi]) begin
          hold_cnt_reg <= HOLD_LOAD;
        end else if (hold_cnt_reg != 20'd0) begin
          hold_cnt_reg <= hold_cnt_reg - 20'd1;
        end
      end

      assign hold_zero[gi] = (hold_cnt_reg == 20'd0);
    end
  endgenerate

  assign eligible = pending & hold_zero;

  // Isolating the lowest set bit gives fixed priority channel 0 first.
  always_comb begin
    state_next  = state_reg;
    settle_next = settle_reg;
    toggle_mask = 4'd0;
    case (state_reg)
      IDLE: begin
        if (|eligible) begin
          toggle_mask = eligible & (~eligible + 4'd1);
          settle_next = SETTLE_LOAD;
          state_next  = SETTLE;
        end
      end
      SETTLE: begin
        if (settle_reg == 16'd0) begin
          state_next = IDLE;
        end else begin
          settle_next = settle_reg - 16'd1;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign drive_next = drive_reg ^ toggle_mask;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg  <= IDLE;
      settle_reg <= 16'd0;
      drive_reg  <= 4'd0;
    end else begin
      state_reg  <= state_next;
      settle_reg <= settle_next;
      drive_reg  <= drive_next;
    end
  end

`ifdef IOT_RELAY_DRIVER_STATS_EN
  logic [15:0] switch_count_reg;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      switch_count_reg <= 16'd0;
    end else if ((|toggle_mask) && (switch_count_reg != 16'hFFFF)) begin
      switch_count_reg <= switch_count_reg + 16'd1;
    end
  end

  assign bus.switch_count = switch_count_reg;
`endif

  assign bus.drive   = drive_reg;
  assign bus.pending = pending;
  assign bus.busy    = (state_reg == SETTLE) || (|pending);

endmodule

// File: tb/tb_iot_relay_driver.sv
// Scoreboard bench for iot_relay_driver with SETTLE_CYCLES=4, HOLD_CYCLES=10.
module tb_iot_relay_driver;

  typedef struct {
    int         at;
    logic [3:0] val;
  } ev_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;

  iot_relay_driver_if bus ();

  iot_relay_driver #(
    .SETTLE_CYCLES(4),
    .HOLD_CYCLES  (10)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  int n_compared = 0;
  int n_mismatched = 0;

  ev_t        exp_q[$];
  ev_t        obs_q[$];
  logic       busy_hist[0:63];
  logic [3:0] pend_hist[0:63];

  // Holds reset for two cycles, then releases it together with the first request.
  task automatic apply_reset(input logic [3:0] cmd);
    @(negedge clk);
    reset_n    = 1'b0;
    bus.cmd_in = 4'd0;
    repeat (2) @(negedge clk);
    reset_n    = 1'b1;
    bus.cmd_in = cmd;
    exp_q.delete();
    obs_q.delete();
  endtask

  // Edge 1 is the first rising edge after the call; records drive changes and status per edge.
  task automatic observe(input int n, input int c1e, input logic [3:0] c1v,
                         input int c2e, input logic [3:0] c2v);
    logic [3:0] prev;
    ev_t        ev;
    prev = bus.drive;
    for (int e = 1; e <= n; e++) begin
      @(posedge clk);
      #1;
      if (bus.drive !== prev) begin
        ev.at  = e;
        ev.val = bus.drive;
        obs_q.push_back(ev);
        $display("edge %0d: drive %b -> %b", e, prev, bus.drive);
        prev = bus.drive;
      end
      busy_hist[e] = bus.busy;
      pend_hist[e] = bus.pending;
      if (e + 1 == c1e) bus.cmd_in = c1v;
      if (e + 1 == c2e) bus.cmd_in = c2v;
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset_n    = 1'b0;
    bus.cmd_in = 4'b1111;
    repeat (3) begin
      @(posedge clk);
      #1;
      n_compared++;
      if (bus.drive !== 4'b0000) begin
        n_mismatched++;
        $display("FAIL reset_drive: got %b want 0000", bus.drive);
      end
      n_compared++;
      if (bus.pending !== 4'b0000) begin
        n_mismatched++;
        $display("FAIL reset_pending: got %b want 0000", bus.pending);
      end
      n_compared++;
      if (bus.busy !== 1'b0) begin
        n_mismatched++;
        $display("FAIL reset_busy: got %b want 0", bus.busy);
      end
`ifdef IOT_RELAY_DRIVER_STATS_EN
      n_compared++;
      if (bus.switch_count !== 16'd0) begin
        n_mismatched++;
        $display("FAIL reset_count: got %0d want 0", bus.switch_count);
      end
`endif
    end
    $display("test_reset done");
  endtask

  task automatic test_two_channels();
    ev_t ex, ob;
    apply_reset(4'b0101);
    exp_q.push_back('{2, 4'b0001});
    exp_q.push_back('{7, 4'b0101});
    observe(16, -1, 4'd0, -1, 4'd0);
    while (exp_q.size() > 0) begin
      ex = exp_q.pop_front();
      n_compared++;
      if (obs_q.size() == 0) begin
        n_mismatched++;
        $display("FAIL two_ch_missing: no toggle, want %b at edge %0d", ex.val, ex.at);
      end else begin
        ob = obs_q.pop_front();
        if (ob.at !== ex.at || ob.val !== ex.val) begin
          n_mismatched++;
          $display("FAIL two_ch_toggle: got %b at edge %0d want %b at edge %0d", ob.val, ob.at, ex.val, ex.at);
        end
      end
    end
    n_compared++;
    if (obs_q.size() != 0) begin
      n_mismatched++;
      $display("FAIL two_ch_extra: got %0d extra toggles want 0", obs_q.size());
    end
    n_compared++;
    if (pend_hist[1] !== 4'b0101) begin
      n_mismatched++;
      $display("FAIL two_ch_pending: got %b want 0101", pend_hist[1]);
    end
    n_compared++;
    if (busy_hist[10] !== 1'b1 || busy_hist[11] !== 1'b0) begin
      n_mismatched++;
      $display("FAIL two_ch_busy: got %b%b at edges 10/11 want 10", busy_hist[10], busy_hist[11]);
    end
    $display("test_two_channels done");
  endtask

  task automatic test_hold();
    ev_t ex, ob;
    apply_reset(4'b0001);
    exp_q.push_back('{2, 4'b0001});
    exp_q.push_back('{12, 4'b0000});
    observe(18, 3, 4'b0000, -1, 4'd0);
    while (exp_q.size() > 0) begin
      ex = exp_q.pop_front();
      n_compared++;
      if (obs_q.size() == 0) begin
        n_mismatched++;
        $display("FAIL hold_missing: no toggle, want %b at edge %0d", ex.val, ex.at);
      end else begin
        ob = obs_q.pop_front();
        if (ob.at !== ex.at || ob.val !== ex.val) begin
          n_mismatched++;
          $display("FAIL hold_toggle: got %b at edge %0d want %b at edge %0d", ob.val, ob.at, ex.val, ex.at);
        end
      end
    end
    n_compared++;
    if (obs_q.size() != 0) begin
      n_mismatched++;
      $display("FAIL hold_extra: got %0d extra toggles want 0", obs_q.size());
    end
    n_compared++;
    if (busy_hist[11] !== 1'b1) begin
      n_mismatched++;
      $display("FAIL hold_busy: got %b at edge 11 want 1", busy_hist[11]);
    end
    $display("test_hold done");
  endtask

  task automatic test_glitch();
    ev_t ex, ob;
    apply_reset(4'b0001);
    exp_q.push_back('{2, 4'b0001});
    observe(12, 3, 4'b0011, 4, 4'b0001);
    while (exp_q.size() > 0) begin
      ex = exp_q.pop_front();
      n_compared++;
      if (obs_q.size() == 0) begin
        n_mismatched++;
        $display("FAIL glitch_missing: no toggle, want %b at edge %0d", ex.val, ex.at);
      end else begin
        ob = obs_q.pop_front();
        if (ob.at !== ex.at || ob.val !== ex.val) begin
          n_mismatched++;
          $display("FAIL glitch_toggle: got %b at edge %0d want %b at edge %0d", ob.val, ob.at, ex.val, ex.at);
        end
      end
    end
    n_compared++;
    if (obs_q.size() != 0) begin
      n_mismatched++;
      $display("FAIL glitch_extra: got %0d extra toggles want 0", obs_q.size());
    end
    n_compared++;
    if (pend_hist[3] !== 4'b0010 || pend_hist[4] !== 4'b0000) begin
      n_mismatched++;
      $display("FAIL glitch_pending: got %b/%b at edges 3/4 want 0010/0000", pend_hist[3], pend_hist[4]);
    end
`ifdef IOT_RELAY_DRIVER_STATS_EN
    n_compared++;
    if (bus.switch_count !== 16'd1) begin
      n_mismatched++;
      $display("FAIL glitch_count: got %0d want 1", bus.switch_count);
    end
`endif
    $display("test_glitch done");
  endtask

  task automatic test_back_to_back();
    ev_t ex, ob;
    apply_reset(4'b1111);
    exp_q.push_back('{2, 4'b0001});
    exp_q.push_back('{7, 4'b0011});
    exp_q.push_back('{12, 4'b0111});
    exp_q.push_back('{17, 4'b1111});
    observe(22, -1, 4'd0, -1, 4'd0);
    while (exp_q.size() > 0) begin
      ex = exp_q.pop_front();
      n_compared++;
      if (obs_q.size() == 0) begin
        n_mismatched++;
        $display("FAIL b2b_missing: no toggle, want %b at edge %0d", ex.val, ex.at);
      end else begin
        ob = obs_q.pop_front();
        if (ob.at !== ex.at || ob.val !== ex.val) begin
          n_mismatched++;
          $display("FAIL b2b_toggle: got %b at edge %0d want %b at edge %0d", ob.val, ob.at, ex.val, ex.at);
        end
      end
    end
    n_compared++;
    if (obs_q.size() != 0) begin
      n_mismatched++;
      $display("FAIL b2b_extra: got %0d extra toggles want 0", obs_q.size());
    end
    n_compared++;
    if (busy_hist[20] !== 1'b1 || busy_hist[21] !== 1'b0) begin
      n_mismatched++;
      $display("FAIL b2b_busy: got %b%b at edges 20/21 want 10", busy_hist[20], busy_hist[21]);
    end
`ifdef IOT_RELAY_DRIVER_STATS_EN
    n_compared++;
    if (bus.switch_count !== 16'd4) begin
      n_mismatched++;
      $display("FAIL b2b_count: got %0d want 4", bus.switch_count);
    end
`endif
    $display("test_back_to_back done");
  endtask

  task automatic test_reset_mid_settle();
    ev_t ex, ob;
    apply_reset(4'b0101);
    exp_q.push_back('{2, 4'b0001});
    observe(3, -1, 4'd0, -1, 4'd0);
    reset_n = 1'b0;
    #1;
    n_compared++;
    if (bus.drive !== 4'b0000 || bus.busy !== 1'b0) begin
      n_mismatched++;
      $display("FAIL midrst_async: got drive %b busy %b want 0000/0", bus.drive, bus.busy);
    end
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    exp_q.push_back('{2, 4'b0001});
    exp_q.push_back('{7, 4'b0101});
    observe(12, -1, 4'd0, -1, 4'd0);
    while (exp_q.size() > 0) begin
      ex = exp_q.pop_front();
      n_compared++;
      if (obs_q.size() == 0) begin
        n_mismatched++;
        $display("FAIL midrst_missing: no toggle, want %b at edge %0d", ex.val, ex.at);
      end else begin
        ob = obs_q.pop_front();
        if (ob.at !== ex.at || ob.val !== ex.val) begin
          n_mismatched++;
          $display("FAIL midrst_toggle: got %b at edge %0d want %b at edge %0d", ob.val, ob.at, ex.val, ex.at);
        end
      end
    end
    n_compared++;
    if (obs_q.size() != 0) begin
      n_mismatched++;
      $display("FAIL midrst_extra: got %0d extra toggles want 0", obs_q.size());
    end
    $display("test_reset_mid_settle done");
  endtask

  initial begin
    bus.cmd_in = 4'd0;
    test_reset();
    test_two_channels();
    test_hold();
    test_glitch();
    test_back_to_back();
    test_reset_mid_settle();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule

// File: doc/iot_relay_driver.md
IOT_RELAY_DRIVER -- requirements
Module: iot_relay_driver

Interface
REQ-001 Parameter SETTLE_CYCLES, 1000, minimum idle cycles after any output switch before the next switch; legal range 1..65535.
REQ-002 Parameter HOLD_CYCLES, 50000, minimum cycles a channel stays in a state before it may toggle again; legal range 1..2^20-1.
REQ-003 clk  input  1  system clock; all logic on rising edge.
REQ-004 reset_n  input  1  reset, asynchronous, active-low.
REQ-005 cmd_in  input  4  requested channel levels, driven by the 4-bit output PIO out_port, same clock domain.
REQ-006 drive  output  4  registered relay/actuator drive levels.
REQ-007 busy  output  1  high while any channel differs from its request or a settle interval runs.
REQ-008 pending  output  4  registered-request XOR drive, per channel.
REQ-009 switch_count  output  16  total output toggles since reset (present only with IOT_RELAY_DRIVER_STATS_EN).

Function
REQ-010 cmd_in shall be registered once into cmd_q; all decisions use cmd_q only.
REQ-011 pending shall equal cmd_q XOR drive, combinationally from registers.
REQ-012 Each channel shall own a hold counter; on that channel's toggle it loads HOLD_CYCLES-1, then decrements by 1 per cycle to 0 and stops.
REQ-013 A channel is eligible when its pending bit is 1 and its hold counter is 0.
REQ-014 FSM states IDLE and SETTLE only.
REQ-015 IDLE: if any channel eligible, toggle drive of the lowest-index eligible channel only, load settle counter with SETTLE_CYCLES-1, go SETTLE; else stay IDLE.
REQ-016 SETTLE: if settle counter is 0 go IDLE, else decrement; no drive change in SETTLE.
REQ-017 Consecutive toggles (any channels) shall be at least SETTLE_CYCLES+1 cycles apart; at most one drive bit changes per cycle.
REQ-018 Latency: cmd_in change sampled at edge N shall toggle drive at edge N+1 when IDLE and eligible.
REQ-019 A request reverting before being applied clears pending; drive shall not toggle.
REQ-020 A request change on a channel already in hold shall wait; it is applied at the first IDLE cycle after hold expires, subject to priority.
REQ-021 Simultaneous requests on multiple channels are served one per settle interval in index order 0..3 (fixed priority, re-evaluated each IDLE cycle).
REQ-022 busy = (state == SETTLE) OR (|pending).

Reset
REQ-023 reset_n low shall asynchronously force: cmd_q=0, drive=0, all hold counters=0, settle counter=0, state=IDLE, switch_count=0; hence pending=0, busy=0.
REQ-024 Reset asserted mid-settle or mid-hold shall abandon all timing; after release, channels are immediately eligible.
REQ-025 After reset release, the first cmd_in sample occurs on the first rising edge with reset_n high.

Configuration
REQ-026 Macro IOT_RELAY_DRIVER_STATS_EN defined: switch_count port exists, increments by 1 on every drive toggle, saturates at 0xFFFF.
REQ-027 Macro undefined: switch_count port and its counter are absent; all other behaviour is identical.

Verification (SETTLE_CYCLES=4, HOLD_CYCLES=10)
REQ-028 Reset asserted with cmd_in=1111 -> drive=0000, pending=0000, busy=0, switch_count=0 while reset_n low.
REQ-029 cmd_in 0000->0101 sampled at edge 1 -> drive=0001 at edge 2, drive=0101 at edge 7, busy low from edge 11.
REQ-030 cmd_in=0001 sampled at edge 1, then 0000 from edge 3 -> drive bit0 set at edge 2, cleared at edge 12 (hold), not earlier.
REQ-031 cmd_in=0010 sampled for one cycle only while SETTLE active -> pending pulses, drive bit1 never toggles, switch_count unchanged.
REQ-032 cmd_in=1111 sampled at edge 1 -> drive steps 0001, 0011, 0111, 1111 at edges 2, 7, 12, 17; switch_count=4 (STATS_EN).
REQ-033 reset_n pulsed low at edge 4 during REQ-029 sequence -> drive=0000 immediately; after release with cmd_in=0101, drive=0001 one edge after first sample.
